// File: rtl/pwm_multi.sv
// Multi-channel PWM generator sharing one period counter; edge- or center-aligned,
// per-channel polarity, with period/duty/polarity/mode double-buffered to period boundaries.
module pwm_multi #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [WIDTH-1:0]          period_in,
  input  logic [CHANNELS*WIDTH-1:0] duty_in,
  input  logic [CHANNELS-1:0]       polarity_in,
  input  logic                      center_in,
  input  logic                      load,
  output logic                      load_pending,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      sync
);

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]          cnt_q;
  dir_e                      dir_q;
  logic [WIDTH-1:0]          per_q, stg_per_q;
  logic [CHANNELS*WIDTH-1:0] duty_q, stg_duty_q;
  logic [CHANNELS-1:0]       pol_q, stg_pol_q;
  logic                      center_q, stg_center_q;
  logic                      pend_q;
  logic [CHANNELS-1:0]       pwm_q;
  logic                      sync_q;

  logic                      per_zero;
  logic                      last_up;
  logic                      boundary;
  logic                      swap;
  logic [CHANNELS-1:0]       raw;
  logic [WIDTH-1:0]          d;
  logic [WIDTH-1:0]          dmin;

  assign per_zero = (per_q == '0);
  assign last_up  = (cnt_q == per_q - ONE);
  // Stopped or zero-period: every cycle is a boundary so pending loads land at once.
  assign boundary = !enable || per_zero ||
                    (center_q ? (dir_q == DIR_DOWN && cnt_q == '0) : last_up);
  assign swap     = boundary && pend_q;

  always_comb begin
    raw  = '0;
    d    = '0;
    dmin = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      d    = duty_q[i*WIDTH +: WIDTH];
      dmin = (d > per_q) ? per_q : d;
      if (!per_zero) begin
        raw[i] = center_q ? (cnt_q >= per_q - dmin) : (cnt_q < d);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      dir_q        <= DIR_UP;
      per_q        <= '0;
      duty_q       <= '0;
      pol_q        <= '0;
      center_q     <= 1'b0;
      stg_per_q    <= '0;
      stg_duty_q   <= '0;
      stg_pol_q    <= '0;
      stg_center_q <= 1'b0;
      pend_q       <= 1'b0;
      pwm_q        <= '0;
      sync_q       <= 1'b0;
    end else begin
      // A load coinciding with a boundary is staged for the following boundary.
      if (load) begin
        stg_per_q    <= period_in;
        stg_duty_q   <= duty_in;
        stg_pol_q    <= polarity_in;
        stg_center_q <= center_in;
        pend_q       <= 1'b1;
      end else if (swap) begin
        pend_q       <= 1'b0;
      end

      if (swap) begin
        per_q    <= stg_per_q;
        duty_q   <= stg_duty_q;
        pol_q    <= stg_pol_q;
        center_q <= stg_center_q;
      end

      if (!enable) begin
        pwm_q  <= pol_q;
        sync_q <= 1'b0;
      end else begin
        pwm_q  <= raw ^ pol_q;
        sync_q <= (cnt_q == '0) && (dir_q == DIR_UP);
      end

      // Center mode holds each extreme for two cycles: the turn happens without a step.
      if (boundary) begin
        cnt_q <= '0;
        dir_q <= DIR_UP;
      end else if (center_q) begin
        if (dir_q == DIR_UP) begin
          if (last_up) dir_q <= DIR_DOWN;
          else         cnt_q <= cnt_q + ONE;
        end else begin
          cnt_q <= cnt_q - ONE;
        end
      end else begin
        cnt_q <= cnt_q + ONE;
      end
    end
  end

  assign load_pending = pend_q;
  assign pwm_out      = pwm_q;
  assign sync         = sync_q;

endmodule
